// File: rtl/sie_tx_cmd_queue.sv
// sie_tx_cmd_queue: buffers muxed SIE port writes ({ctrl, data}) and issues them
// one at a time to the SIE transmitter with a txStart/txDone handshake.
// A change of hostMode flushes the queue.
// Optional build macro SIE_TX_CMD_TIMEOUT_EN adds the TIMEOUT_CYCLES parameter and
// a WAIT watchdog that sets the sticky timeoutErr; without it timeoutErr is 0.
module sie_tx_cmd_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
`ifdef SIE_TX_CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              usbClk,
    input  logic              rstSyncToUsbClk,
    input  logic [7:0]        SIEPortCtrlIn,
    input  logic [7:0]        SIEPortDataIn,
    input  logic              SIEPortWEn,
    input  logic              hostMode,
    input  logic              clrErr,
    output logic              txStart,
    output logic [7:0]        txCtrl,
    output logic [7:0]        txData,
    input  logic              txDone,
    output logic              txBusy,
    output logic [ADDR_W:0]   queueCount,
    output logic              queueFull,
    output logic              overflowErr,
    output logic              timeoutErr
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } stateT;

    stateT             state;
    logic              modeQ;
    logic [15:0]       fifoMem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [CNT_W-1:0]  countNext;
    logic              flush;
    logic              full;
    logic              popEn;
    logic              pushEn;
    logic              ovfSet;

    // Queue control: a pop in the same cycle frees a slot for a push even when full
    assign flush  = (hostMode != modeQ);
    assign full   = (queueCount == CNT_W'(DEPTH));
    assign popEn  = (state == IDLE) && (queueCount != '0) && !flush;
    assign pushEn = SIEPortWEn && !flush && (!full || popEn);
    assign ovfSet = SIEPortWEn && !flush && full && !popEn;

    // Next occupancy from push/pop/flush
    always_comb begin
        countNext = queueCount;
        if (flush) begin
            countNext = '0;
        end else if (pushEn && !popEn) begin
            countNext = queueCount + CNT_W'(1);
        end else if (popEn && !pushEn) begin
            countNext = queueCount - CNT_W'(1);
        end
    end

    // Mode tracking; loads during reset so reset release never flushes
    always_ff @(posedge usbClk) begin
        modeQ <= hostMode;
    end

    // Entry storage
    always_ff @(posedge usbClk) begin
        if (pushEn) begin
            fifoMem[wrPtr] <= {SIEPortCtrlIn, SIEPortDataIn};
        end
    end

    // Pointers, occupancy and full flag
    always_ff @(posedge usbClk) begin
        if (rstSyncToUsbClk) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            queueCount <= '0;
            queueFull  <= 1'b0;
        end else begin
            queueCount <= countNext;
            queueFull  <= (countNext == CNT_W'(DEPTH));
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (pushEn) wrPtr <= wrPtr + ADDR_W'(1);
                if (popEn)  rdPtr <= rdPtr + ADDR_W'(1);
            end
        end
    end

`ifdef SIE_TX_CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] waitCnt;
    logic            timeoutHit;

    // Watchdog expires on the last allowed WAIT cycle; txDone in that cycle wins
    assign timeoutHit = (state == WAIT) && !txDone &&
                        (waitCnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    // Issue FSM with registered handshake outputs
    always_ff @(posedge usbClk) begin
        if (rstSyncToUsbClk) begin
            state   <= IDLE;
            txStart <= 1'b0;
            txBusy  <= 1'b0;
            txCtrl  <= 8'h00;
            txData  <= 8'h00;
`ifdef SIE_TX_CMD_TIMEOUT_EN
            waitCnt <= '0;
`endif
        end else begin
            txStart <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (popEn) begin
                        state            <= START;
                        txStart          <= 1'b1;
                        txBusy           <= 1'b1;
                        {txCtrl, txData} <= fifoMem[rdPtr];
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef SIE_TX_CMD_TIMEOUT_EN
                    waitCnt <= '0;
`endif
                end
                WAIT: begin
                    if (txDone) begin
                        state  <= IDLE;
                        txBusy <= 1'b0;
                    end
`ifdef SIE_TX_CMD_TIMEOUT_EN
                    else if (timeoutHit) begin
                        state  <= IDLE;
                        txBusy <= 1'b0;
                    end else begin
                        waitCnt <= waitCnt + TO_W'(1);
                    end
`endif
                end
                default: begin
                    state  <= IDLE;
                    txBusy <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a set beats a coincident clear
    always_ff @(posedge usbClk) begin
        if (rstSyncToUsbClk) begin
            overflowErr <= 1'b0;
        end else if (ovfSet) begin
            overflowErr <= 1'b1;
        end else if (clrErr) begin
            overflowErr <= 1'b0;
        end
    end

`ifdef SIE_TX_CMD_TIMEOUT_EN
    // Sticky watchdog flag; a set beats a coincident clear
    always_ff @(posedge usbClk) begin
        if (rstSyncToUsbClk) begin
            timeoutErr <= 1'b0;
        end else if (timeoutHit) begin
            timeoutErr <= 1'b1;
        end else if (clrErr) begin
            timeoutErr <= 1'b0;
        end
    end
`else
    assign timeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_sie_tx_cmd_queue.sv
// Bench for sie_tx_cmd_queue: a queue-level reference model checked every cycle,
// plus hand-computed literal checks along the directed scenarios.
module tb_sie_tx_cmd_queue;

    localparam int DEPTH = 4;
`ifdef SIE_TX_CMD_TIMEOUT_EN
    localparam int TO = 8;
`endif

    logic       usbClk;
    logic       rstSyncToUsbClk;
    logic [7:0] SIEPortCtrlIn;
    logic [7:0] SIEPortDataIn;
    logic       SIEPortWEn;
    logic       hostMode;
    logic       clrErr;
    logic       txStart;
    logic [7:0] txCtrl;
    logic [7:0] txData;
    logic       txDone;
    logic       txBusy;
    logic [2:0] queueCount;
    logic       queueFull;
    logic       overflowErr;
    logic       timeoutErr;

    int errors = 0;
    int checks = 0;

    initial usbClk = 1'b0;
    always #5 usbClk = ~usbClk;

    sie_tx_cmd_queue #(
        .DEPTH(4),
        .ADDR_W(2)
`ifdef SIE_TX_CMD_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .usbClk(usbClk),
        .rstSyncToUsbClk(rstSyncToUsbClk),
        .SIEPortCtrlIn(SIEPortCtrlIn),
        .SIEPortDataIn(SIEPortDataIn),
        .SIEPortWEn(SIEPortWEn),
        .hostMode(hostMode),
        .clrErr(clrErr),
        .txStart(txStart),
        .txCtrl(txCtrl),
        .txData(txData),
        .txDone(txDone),
        .txBusy(txBusy),
        .queueCount(queueCount),
        .queueFull(queueFull),
        .overflowErr(overflowErr),
        .timeoutErr(timeoutErr)
    );

    // Reference model: pending commands, one in-flight transfer, sticky flags
    logic [15:0] mq[$];
    bit          mBusy;
    bit          mStart;
    logic [7:0]  mCtrl;
    logic [7:0]  mData;
    bit          mOvf;
    bit          mTo;
    bit          mMode;
    int          mWait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        bit flush;
        bit popEv;
        bit ovfSet;
        bit toSet;
        int sz;
        ovfSet = 0;
        toSet  = 0;
        if (rstSyncToUsbClk) begin
            mq.delete();
            mBusy = 0; mStart = 0; mCtrl = 0; mData = 0;
            mOvf = 0; mTo = 0; mWait = 0; mMode = hostMode;
            return;
        end
        flush = (hostMode != mMode);
        mMode = hostMode;
        sz    = mq.size();
        popEv = !mBusy && sz > 0 && !flush;
        // transmitter side: idle -> issue, first busy cycle ignores txDone
        if (!mBusy) begin
            if (popEv) begin
                {mCtrl, mData} = mq.pop_front();
                mBusy  = 1;
                mStart = 1;
                mWait  = 0;
            end
        end else if (mStart) begin
            mStart = 0;
            mWait  = 0;
        end else if (txDone) begin
            mBusy = 0;
        end else begin
`ifdef SIE_TX_CMD_TIMEOUT_EN
            mWait++;
            if (mWait == TO) begin
                mBusy = 0;
                toSet = 1;
            end
`endif
        end
        // queue side
        if (flush) begin
            mq.delete();
        end else if (SIEPortWEn) begin
            if (sz < DEPTH || popEv) mq.push_back({SIEPortCtrlIn, SIEPortDataIn});
            else ovfSet = 1;
        end
        mOvf = ovfSet ? 1'b1 : (clrErr ? 1'b0 : mOvf);
        mTo  = toSet  ? 1'b1 : (clrErr ? 1'b0 : mTo);
    endtask

    task automatic compareAll();
        chk("txStart", txStart, mStart);
        chk("txBusy", txBusy, mBusy);
        chk("txCtrl", txCtrl, mCtrl);
        chk("txData", txData, mData);
        chk("queueCount", queueCount, mq.size());
        chk("queueFull", queueFull, (mq.size() == DEPTH));
        chk("overflowErr", overflowErr, mOvf);
        chk("timeoutErr", timeoutErr, mTo);
    endtask

    // One clock: model consumes current inputs, DUT clocks, outputs compared mid-cycle
    task automatic cycle();
        modelStep();
        @(posedge usbClk);
        @(negedge usbClk);
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [7:0] c, input logic [7:0] d);
        SIEPortWEn    = 1'b1;
        SIEPortCtrlIn = c;
        SIEPortDataIn = d;
        cycle();
        SIEPortWEn    = 1'b0;
    endtask

    task automatic done();
        txDone = 1'b1;
        cycle();
        txDone = 1'b0;
    endtask

    // Called one cycle after a txDone pulse; next issue must come exactly 2 cycles after it
    task automatic expectIssue(input logic [7:0] expCtrl);
        int n;
        n = 1;
        while (txStart !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        chk("issue_latency", n, 2);
        chk("issue_ctrl", txCtrl, expCtrl);
    endtask

    initial begin
        rstSyncToUsbClk = 1'b1;
        SIEPortCtrlIn   = 8'h00;
        SIEPortDataIn   = 8'h00;
        SIEPortWEn      = 1'b0;
        hostMode        = 1'b0;
        clrErr          = 1'b0;
        txDone          = 1'b0;
        @(negedge usbClk);
        idle(2);
        chk("reset_busy", txBusy, 0);
        chk("reset_count", queueCount, 0);
        rstSyncToUsbClk = 1'b0;
        idle(1);

        // single write into empty queue: txStart two cycles later
        wr(8'h03, 8'hA5);
        chk("t1_count_c1", queueCount, 1);
        cycle();
        chk("t1_start", txStart, 1);
        chk("t1_ctrl", txCtrl, 8'h03);
        chk("t1_data", txData, 8'hA5);
        chk("t1_busy", txBusy, 1);
        chk("t1_count_c2", queueCount, 0);

        // five writes while a command is in flight: fifth dropped
        for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), 8'h20 + 8'(i));
        chk("t2_count", queueCount, 4);
        chk("t2_full", queueFull, 1);
        chk("t2_ovf", overflowErr, 1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            done();
            expectIssue(8'h10 + 8'(i));
        end
        chk("t2_last_data", txData, 8'h23);
        idle(1);
        done();
        chk("t2_idle", txBusy, 0);
        clrErr = 1'b1;
        cycle();
        clrErr = 1'b0;
        chk("t2_clr", overflowErr, 0);

        // flush with 3 queued and a command in WAIT
        for (int i = 0; i < 4; i++) wr(8'h30 + 8'(i), 8'h40 + 8'(i));
        chk("t3_count", queueCount, 3);
        chk("t3_busy", txBusy, 1);
        hostMode = 1'b1;
        cycle();
        chk("t3_flushed", queueCount, 0);
        done();
        chk("t3_idle", txBusy, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t3_no_start", txStart, 0);
        end

        // write coinciding with a mode toggle is discarded
        SIEPortWEn    = 1'b1;
        SIEPortCtrlIn = 8'h44;
        hostMode      = 1'b0;
        cycle();
        SIEPortWEn    = 1'b0;
        chk("t4_count", queueCount, 0);
        chk("t4_ovf", overflowErr, 0);
        idle(2);
        chk("t4_idle", txBusy, 0);

        // pop and push together while full
        for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i), 8'h60 + 8'(i));
        chk("t5_full", queueFull, 1);
        done();
        chk("t5_idle", txBusy, 0);
        chk("t5_count_pre", queueCount, 4);
        wr(8'h55, 8'h65);
        chk("t5_count_keep", queueCount, 4);
        chk("t5_issue", txCtrl, 8'h51);
        chk("t5_no_ovf", overflowErr, 0);
        clrErr = 1'b1;
        wr(8'h56, 8'h66);
        clrErr = 1'b0;
        chk("t5_set_wins", overflowErr, 1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            done();
            expectIssue(8'h52 + 8'(i));
        end
        idle(1);
        done();
        idle(1);

        // reset mid-operation
        for (int i = 0; i < 3; i++) wr(8'h70 + 8'(i), 8'h80);
        rstSyncToUsbClk = 1'b1;
        cycle();
        rstSyncToUsbClk = 1'b0;
        chk("rst_count", queueCount, 0);
        chk("rst_busy", txBusy, 0);
        chk("rst_ctrl", txCtrl, 0);
        chk("rst_ovf", overflowErr, 0);
        idle(3);

`ifdef SIE_TX_CMD_TIMEOUT_EN
        // watchdog: 8 WAIT cycles then back to IDLE with timeoutErr
        wr(8'h90, 8'h91);
        cycle();
        chk("t6_start", txStart, 1);
        for (int i = 0; i < TO; i++) begin
            cycle();
            chk("t6_waiting", txBusy, 1);
        end
        cycle();
        chk("t6_released", txBusy, 0);
        chk("t6_err", timeoutErr, 1);
        clrErr = 1'b1;
        cycle();
        clrErr = 1'b0;
        chk("t6_clr", timeoutErr, 0);
`else
        chk("no_timeout", timeoutErr, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
